// File: rtl/instr_sequencer.sv
// instr_sequencer: encodes an instruction from the enc_* fields, appends it
// to a 16-entry program buffer on wr_btn and issues buffered instructions
// one at a time on step_btn. A three-state FSM (IDLE/ISSUE/HALT) controls
// issuing, and the current state is visible on state_dbg.
// Optional feature macro: LOOP_WRAP_EN. When it is defined, stepping past
// the last stored entry wraps around to entry 0 instead of halting.
//
// Handshake: wr_btn, step_btn and run_clr are single-cycle pulses sampled on
// the rising edge. Each issue raises instr_valid for exactly one cycle, and
// instructions holds the issued word until the next issue.
module instr_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  enc_op,
    input  logic [2:0]  enc_dst,
    input  logic [2:0]  enc_srca,
    input  logic [2:0]  enc_srcb,
    input  logic [3:0]  enc_addr,
    input  logic        wr_btn,
    input  logic        step_btn,
    input  logic        run_clr,
    output logic [11:0] instructions,
    output logic        instr_valid,
    output logic [3:0]  pc,
    output logic [4:0]  count,
    output logic        full,
    output logic        empty,
    output logic        halted,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    // pc_q is one bit wider than the pc port so that it can reach 16 and
    // compare equal to a full count. Without that extra bit it would wrap to
    // 0 after entry 15 was issued.
    logic [4:0]  pc_q, pc_d;
    logic [4:0]  count_q, count_d;
    logic [11:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [11:0] enc_word;
    logic        full_w;
    logic        wr_accept;
    logic [11:0] prog_mem [16];

    assign full_w    = (count_q == 5'd16);
    assign wr_accept = wr_btn && !full_w;

    // Combinational encoder from the enc_* fields into a 12-bit word.
    always_comb begin
        enc_word = 12'd0;
        case (enc_op)
            2'b00:   enc_word = {3'b000, 2'b00, enc_dst, enc_addr};
            2'b01:   enc_word = {3'b001, 2'b00, enc_srca, enc_addr};
            2'b10:   enc_word = {3'b101, enc_dst, enc_srcb, enc_srca};
            default: enc_word = {3'b110, enc_dst, enc_srcb, enc_srca};
        endcase
    end

    // Program buffer write port. Entries at or above count are never issued,
    // so the buffer does not need a reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            prog_mem[count_q[3:0]] <= enc_word;
        end
    end

    // State and datapath registers. Reset clears everything asynchronously,
    // which also drops an in-flight instr_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= 5'd0;
            count_q <= 5'd0;
            instr_q <= 12'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic. Writes are accepted in every state. The step
    // decision uses the count value from before the edge, and run_clr takes
    // priority over step_btn.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        instr_d = instr_q;
        valid_d = 1'b0;

        if (wr_accept) begin
            count_d = count_q + 5'd1;
        end

        if (run_clr) begin
            state_d = S_IDLE;
            pc_d    = 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (step_btn) begin
                        if (pc_q < count_q) begin
                            instr_d = prog_mem[pc_q[3:0]];
                            valid_d = 1'b1;
                            pc_d    = pc_q + 5'd1;
                            state_d = S_ISSUE;
                        end else begin
`ifdef LOOP_WRAP_EN
                            if (count_q != 5'd0) begin
                                instr_d = prog_mem[0];
                                valid_d = 1'b1;
                                pc_d    = 5'd1;
                                state_d = S_ISSUE;
                            end else begin
                                state_d = S_HALT;
                            end
`else
                            state_d = S_HALT;
`endif
                        end
                    end
                end
                S_ISSUE: state_d = S_IDLE;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign instructions = instr_q;
    assign instr_valid  = valid_q;
    assign pc           = pc_q[3:0];
    assign count        = count_q;
    assign full         = full_w;
    assign empty        = (count_q == 5'd0);
    assign halted       = (state_q == S_HALT);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer. For each step that should issue,
// the expected word is pushed into exp_q. A monitor running on the falling
// edge pops and compares one entry every time instr_valid is high.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  enc_op = '0;
    logic [2:0]  enc_dst = '0, enc_srca = '0, enc_srcb = '0;
    logic [3:0]  enc_addr = '0;
    logic        wr_btn = 1'b0, step_btn = 1'b0, run_clr = 1'b0;
    logic [11:0] instructions;
    logic        instr_valid;
    logic [3:0]  pc;
    logic [4:0]  count;
    logic        full, empty, halted;
    logic [1:0]  state_dbg;

    logic [11:0] exp_q[$];
    logic [11:0] model_mem [16];
    int          tests_run = 0;
    int          tests_failed = 0;

    instr_sequencer dut (
        .clk(clk), .reset(reset), .enc_op(enc_op), .enc_dst(enc_dst),
        .enc_srca(enc_srca), .enc_srcb(enc_srcb), .enc_addr(enc_addr),
        .wr_btn(wr_btn), .step_btn(step_btn), .run_clr(run_clr),
        .instructions(instructions), .instr_valid(instr_valid), .pc(pc),
        .count(count), .full(full), .empty(empty), .halted(halted),
        .state_dbg(state_dbg)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoding, used for the bulk fill loop.
    function automatic logic [11:0] ref_enc(input logic [1:0] op, input logic [2:0] d,
                                            input logic [2:0] a, input logic [2:0] b,
                                            input logic [3:0] ad);
        case (op)
            2'b00:   return {5'b00000, d, ad};
            2'b01:   return {5'b00100, a, ad};
            2'b10:   return {3'b101, d, b, a};
            default: return {3'b110, d, b, a};
        endcase
    endfunction

    task automatic set_enc(input logic [1:0] op, input logic [2:0] d, input logic [2:0] a,
                           input logic [2:0] b, input logic [3:0] ad);
        enc_op = op; enc_dst = d; enc_srca = a; enc_srcb = b; enc_addr = ad;
    endtask

    // Drive a one-cycle pulse. The task returns on the falling edge that
    // follows the sampling rising edge.
    task automatic pulse(input logic w, input logic s, input logic r);
        @(negedge clk);
        wr_btn = w; step_btn = s; run_clr = r;
        @(negedge clk);
        wr_btn = 1'b0; step_btn = 1'b0; run_clr = 1'b0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset && instr_valid) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL issue_unexpected: got %0h expected no issue", instructions);
            end else begin
                check("issue_word", {20'd0, instructions}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_instr", instructions, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_halted", halted, 0);

        // add dst=3 srca=1 srcb=2 -> {101,011,010,001} = 0xAD1
        set_enc(2'b10, 3'd3, 3'd1, 3'd2, 4'd0);
        pulse(1, 0, 0);
        check("wr1_count", count, 1);
        check("wr1_empty", empty, 0);
        // load dst=5 addr=0xA -> 0x05A
        set_enc(2'b00, 3'd5, 3'd0, 3'd0, 4'hA);
        pulse(1, 0, 0);
        check("wr2_count", count, 2);

        exp_q.push_back(12'hAD1);
        pulse(0, 1, 0);
        check("step1_pc", pc, 1);
        exp_q.push_back(12'h05A);
        pulse(0, 1, 0);
        check("step2_pc", pc, 2);
        pulse(0, 0, 0);
        check("hold_instr", instructions, 12'h05A);
        check("hold_valid", instr_valid, 0);

        // store srca=4 addr=3 -> {001,00,100,0011} = 0x243
        set_enc(2'b01, 3'd0, 3'd4, 3'd0, 4'd3);
`ifndef LOOP_WRAP_EN
        pulse(0, 1, 0);
        check("halt_flag", halted, 1);
        check("halt_instr", instructions, 12'h05A);
        check("halt_pc", pc, 2);
        // write and step together while halted: the write lands, the step is ignored
        pulse(1, 1, 0);
        check("halt_wr_count", count, 3);
        check("halt_stays", halted, 1);
        // run_clr beats a same-cycle step
        pulse(0, 1, 1);
        check("clr_halted", halted, 0);
        check("clr_pc", pc, 0);
`else
        exp_q.push_back(12'hAD1);
        pulse(0, 1, 0);
        check("wrap_halted", halted, 0);
        check("wrap_pc", pc, 1);
        exp_q.push_back(12'h05A);
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        check("wrap_wr_count", count, 3);
        pulse(0, 1, 1);
        check("clr_pc", pc, 0);
`endif

        // A step held for two cycles: the second cycle lands in ISSUE and is ignored.
        exp_q.push_back(12'hAD1);
        @(negedge clk); step_btn = 1'b1;
        @(negedge clk);
        @(negedge clk); step_btn = 1'b0;
        check("dbl_step_pc", pc, 1);

        // write and step in the same cycle: both take effect
        // sub dst=7 srcb=6 srca=5 -> {110,111,110,101} = 0xDF5
        set_enc(2'b11, 3'd7, 3'd5, 3'd6, 4'd0);
        exp_q.push_back(12'h05A);
        pulse(1, 1, 0);
        check("wr_step_count", count, 4);
        check("wr_step_pc", pc, 2);

        model_mem[0] = 12'hAD1; model_mem[1] = 12'h05A;
        model_mem[2] = 12'h243; model_mem[3] = 12'hDF5;
        // Fill entries 4..15, then one extra write that must be discarded.
        for (int i = 4; i <= 16; i++) begin
            logic [4:0] v;
            v = 5'(i);
            set_enc(v[1:0], v[2:0], ~v[2:0], v[2:0] + 3'd1, v[3:0]);
            if (i < 16) model_mem[i] = ref_enc(v[1:0], v[2:0], ~v[2:0], v[2:0] + 3'd1, v[3:0]);
            pulse(1, 0, 0);
        end
        check("full_count", count, 16);
        check("full_flag", full, 1);

        // Replay the whole buffer; the last word checks that buf[15] survived.
        pulse(0, 0, 1);
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(model_mem[k]);
            pulse(0, 1, 0);
        end
`ifndef LOOP_WRAP_EN
        pulse(0, 1, 0);
        check("full_halt", halted, 1);
`else
        exp_q.push_back(model_mem[0]);
        pulse(0, 1, 0);
        check("full_wrap_halted", halted, 0);
        check("full_wrap_pc", pc, 1);
`endif

        // Reset while in ISSUE clears outputs without waiting for a clock edge.
        pulse(0, 0, 1);
        @(negedge clk); step_btn = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1; step_btn = 1'b0;
        #1;
        check("rst_mid_valid", instr_valid, 0);
        check("rst_mid_instr", instructions, 0);
        check("rst_mid_count", count, 0);
        @(negedge clk); reset = 1'b0;

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
